calc_control: RTL
=================

# calc_control

Sequencing and arithmetic stage directly downstream of the keypad input unit in the two-function (add/subtract) calculator. It consumes the input unit's key strobe, key code and 8-bit two's-complement operand, and latches operand A, the operator and operand B. It then computes an 8-bit signed sum or difference with overflow detection and drives the value to be displayed. It also issues a clear pulse back to the input unit so that a fresh operand can be entered.

## Interface
- WIDTH, 8, operand/result width in bits (two's complement); only 8 is required to be supported.
- CLK  input  1  system clock; all state changes on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- key_valid  input  1  one-cycle strobe, high in the cycle a debounced key is reported (input unit `trig`).
- key_code  input  4  key identity, valid when key_valid=1: 0-9 digit, 10 ADD, 11 SUB, 14 EQUALS, 15 CLEAR, 12/13 unused.
- operand  input  WIDTH  current entry as two's complement (input unit `OUT`); stable except on digit keys.
- disp  output  WIDTH  value to display, two's complement.
- overflow  output  1  last result out of signed range.
- op_sub  output  1  latched operator: 0 add, 1 subtract.
- done  output  1  one-cycle pulse when result/overflow update.
- entry_clr  output  1  one-cycle pulse requesting the input unit clear its digit entry.
- state  output  2  state code for LEDs/debug: 0 ENTER_A, 1 ENTER_B, 2 COMPUTE, 3 RESULT.

## Operation
- Registers: reg_a, reg_b (WIDTH), op_sub, result (WIDTH), overflow, state.
- ENTER_A: disp = operand (live). Digit -> no change. ADD/SUB -> reg_a <= operand, op_sub <= (code==11), entry_clr pulse, go ENTER_B. EQUALS -> ignored.
- ENTER_B: disp = operand. Digit -> no change. ADD/SUB -> op_sub overwritten (operator change, reg_a kept), no entry_clr. EQUALS -> reg_b <= operand, go COMPUTE.
- COMPUTE (exactly one cycle, ignores all keys including CLEAR): 9-bit sign-extended sum s = A + B (add) or A + ~B + 1 (sub); result <= s[7:0]; overflow <= s[8] ^ s[7]; done pulse; entry_clr pulse; go RESULT.
- RESULT: disp = result. Digit -> go ENTER_A (the input unit accepts the digit itself); overflow unchanged. ADD/SUB -> chaining: reg_a <= result, op_sub set, entry_clr pulse, go ENTER_B. EQUALS -> ignored (no repeat).
- CLEAR (codes 15) in ENTER_A/ENTER_B/RESULT: reg_a, reg_b, result <= 0, overflow <= 0, op_sub <= 0, entry_clr pulse, go ENTER_A.
- Codes 12/13: ignored in all states.
- Subtracting -128 is handled by the 9-bit path (no separate negate); e.g. 0 - (-128) gives s=+128 -> result 0x80, overflow=1.

## Timing
- Reset (RESET high at a rising edge): state=ENTER_A, reg_a=reg_b=result=0, op_sub=0, overflow=0, done=0, entry_clr=0; disp then follows operand. RESET has priority over key_valid in the same cycle; reset mid-COMPUTE discards the computation (no done).
- operand and key_code are sampled at the rising edge where key_valid=1; operand must be the value before the key's own effect (true for operator/EQUALS keys).
- entry_clr: registered, high for exactly the cycle after the accepting edge.
- Latency: EQUALS sampled at edge n -> COMPUTE during cycle n..n+1 -> result, overflow, done visible after edge n+1 (done high one cycle). disp switches to result at the same time.
- Back-to-back key_valid in consecutive cycles: each is processed; one arriving during COMPUTE is dropped.
- All outputs registered except disp (mux of operand/result by state).

## Test plan
- Reset then 25, ADD, 17, EQUALS -> state 0->1->2->3, entry_clr after ADD and after COMPUTE, done pulse 2 edges after EQUALS, disp=42 (0x2A), overflow=0.
- 10, SUB, 30, EQUALS -> disp=0xEC (-20), op_sub=1, overflow=0.
- 100, ADD, 50, EQUALS -> disp=0x96, overflow=1; then (-128), SUB, 1, EQUALS -> 0x7F, overflow=1; 0 SUB -128 -> 0x80, overflow=1.
- Chaining: 5 ADD 3 EQUALS (8), SUB, 2, EQUALS -> reg_a=8, disp=6; EQUALS again in RESULT -> no done, disp stays 6.
- Operator change in ENTER_B: 9 ADD, SUB, 4, EQUALS -> disp=5; CLEAR in ENTER_B -> state 0, all registers 0, entry_clr pulse.
- RESET asserted during COMPUTE and simultaneous with key_valid -> no done, state 0, all outputs at reset values.

Source files
------------

// File: rtl/calc_control.sv
// ============================================================================
// Module   : calc_control
// Purpose  : Calculator sequencer that latches A/op/B and computes an 8-bit
//            signed add/sub with overflow, driving the display value.
// Revision : 1.0
// ============================================================================
`default_nettype none

module calc_control #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             key_valid,
    input  logic [3:0]       key_code,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] disp,
    output logic             overflow,
    output logic             op_sub,
    output logic             done,
    output logic             entry_clr,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        S_ENTER_A = 2'd0,
        S_ENTER_B = 2'd1,
        S_COMPUTE = 2'd2,
        S_RESULT  = 2'd3
    } state_t;

    localparam logic [3:0] C_KEY_ADD   = 4'd10;
    localparam logic [3:0] C_KEY_SUB   = 4'd11;
    localparam logic [3:0] C_KEY_EQ    = 4'd14;
    localparam logic [3:0] C_KEY_CLEAR = 4'd15;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   reg_a_q, reg_a_d;
    logic [WIDTH-1:0]   reg_b_q, reg_b_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               op_sub_q, op_sub_d;
    logic               overflow_q, overflow_d;
    logic               done_q, done_d;
    logic               entry_clr_q, entry_clr_d;

    logic               w_digit, w_op, w_eq, w_clear;
    logic [WIDTH:0]     w_a_ext, w_b_ext, w_sum;

    assign w_digit = key_valid && (key_code <= 4'd9);
    assign w_op    = key_valid && ((key_code == C_KEY_ADD) || (key_code == C_KEY_SUB));
    assign w_eq    = key_valid && (key_code == C_KEY_EQ);
    assign w_clear = key_valid && (key_code == C_KEY_CLEAR) && (state_q != S_COMPUTE);

    // One 9-bit path for both operators, so subtracting the most negative
    // value overflows naturally instead of needing a separate negate.
    assign w_a_ext = {reg_a_q[WIDTH-1], reg_a_q};
    assign w_b_ext = op_sub_q ? ~{reg_b_q[WIDTH-1], reg_b_q} : {reg_b_q[WIDTH-1], reg_b_q};
    assign w_sum   = w_a_ext + w_b_ext + {{WIDTH{1'b0}}, op_sub_q};

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= S_ENTER_A;
            reg_a_q     <= '0;
            reg_b_q     <= '0;
            result_q    <= '0;
            op_sub_q    <= 1'b0;
            overflow_q  <= 1'b0;
            done_q      <= 1'b0;
            entry_clr_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            reg_a_q     <= reg_a_d;
            reg_b_q     <= reg_b_d;
            result_q    <= result_d;
            op_sub_q    <= op_sub_d;
            overflow_q  <= overflow_d;
            done_q      <= done_d;
            entry_clr_q <= entry_clr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        reg_a_d     = reg_a_q;
        reg_b_d     = reg_b_q;
        result_d    = result_q;
        op_sub_d    = op_sub_q;
        overflow_d  = overflow_q;
        done_d      = 1'b0;
        entry_clr_d = 1'b0;

        case (state_q)
            S_ENTER_A: begin
                if (w_op) begin
                    reg_a_d     = operand;
                    op_sub_d    = (key_code == C_KEY_SUB);
                    entry_clr_d = 1'b1;
                    state_d     = S_ENTER_B;
                end
            end
            S_ENTER_B: begin
                if (w_op) begin
                    op_sub_d = (key_code == C_KEY_SUB);
                end else if (w_eq) begin
                    reg_b_d = operand;
                    state_d = S_COMPUTE;
                end
            end
            S_COMPUTE: begin
                result_d    = w_sum[WIDTH-1:0];
                overflow_d  = w_sum[WIDTH] ^ w_sum[WIDTH-1];
                done_d      = 1'b1;
                entry_clr_d = 1'b1;
                state_d     = S_RESULT;
            end
            S_RESULT: begin
                if (w_digit) begin
                    state_d = S_ENTER_A;
                end else if (w_op) begin
                    reg_a_d     = result_q;
                    op_sub_d    = (key_code == C_KEY_SUB);
                    entry_clr_d = 1'b1;
                    state_d     = S_ENTER_B;
                end
            end
            default: state_d = S_ENTER_A;
        endcase

        if (w_clear) begin
            reg_a_d     = '0;
            reg_b_d     = '0;
            result_d    = '0;
            op_sub_d    = 1'b0;
            overflow_d  = 1'b0;
            entry_clr_d = 1'b1;
            state_d     = S_ENTER_A;
        end
    end

    assign disp      = (state_q == S_RESULT) ? result_q : operand;
    assign overflow  = overflow_q;
    assign op_sub    = op_sub_q;
    assign done      = done_q;
    assign entry_clr = entry_clr_q;
    assign state     = state_q;

endmodule

`default_nettype wire
